// File: rtl/mcu_dma_addr_arb_if.sv
// Bus-slot signals between the MCU slot sequencer (master) and the address arbiter (slave).
// Channel base/end vectors pack channel n at [n*AW +: AW].
interface mcu_dma_addr_arb_if #(
  parameter int AW  = 23,
  parameter int NCH = 4
);
  logic              slot_stb;
  logic              dma_slot;
  logic [AW-1:0]     cpu_addr;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_start;
  logic [NCH-1:0]    ch_stop;
  logic [NCH-1:0]    ch_loop;
  logic [NCH*AW-1:0] ch_base;
  logic [NCH*AW-1:0] ch_end;
  logic [AW-1:0]     addr;
  logic [1:0]        addr_src;
  logic [NCH-1:0]    ch_gnt;
  logic [NCH-1:0]    ch_active;
  logic [NCH-1:0]    ch_wrap;
  logic [NCH-1:0]    ch_done;

  modport master (
    output slot_stb, dma_slot, cpu_addr, ch_req, ch_start, ch_stop, ch_loop, ch_base, ch_end,
    input  addr, addr_src, ch_gnt, ch_active, ch_wrap, ch_done
  );

  modport slave (
    input  slot_stb, dma_slot, cpu_addr, ch_req, ch_start, ch_stop, ch_loop, ch_base, ch_end,
    output addr, addr_src, ch_gnt, ch_active, ch_wrap, ch_done
  );
endinterface

// File: rtl/mcu_dma_addr_arb.sv
// Per-slot bus address generator: CPU pass-through, periodic refresh rows, or one of NCH
// round-robin DMA channel counters with loop/one-shot end handling.
module mcu_dma_addr_arb #(
  parameter int AW      = 23,
  parameter int NCH     = 4,
  parameter int REF_W   = 8,
  parameter int REF_INT = 4
) (
  input logic              clk,
  input logic              res,
  mcu_dma_addr_arb_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = (REF_INT > 1) ? $clog2(REF_INT) : 1;

  logic [AW-1:0]    addr_reg;
  logic [1:0]       src_reg;
  logic [NCH-1:0]   gnt_reg;
  logic [REF_W-1:0] row_reg;
  logic [DW-1:0]    div_reg;
  logic             pend_reg;
  logic [PW-1:0]    ptr_reg;

  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   active_vec;
  logic [NCH-1:0]   wrap_vec;
  logic [NCH-1:0]   done_vec;
  logic [AW-1:0]    cnt_arr [NCH];
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic             dma_edge;
  logic             div_wrap;

  assign dma_edge = bus.slot_stb & bus.dma_slot;
  assign div_wrap = (div_reg == DW'(REF_INT - 1));
  // A channel being started or stopped this cycle must not also be granted.
  assign eligible = bus.ch_req & active_vec & ~bus.ch_start & ~bus.ch_stop;

  // Round-robin search: scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(ptr_reg) + i;
      if (j >= NCH) j = j - NCH;
      if (eligible[PW'(j)]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [AW-1:0] cnt_reg;
      logic          active_reg;
      logic          wrap_reg;
      logic          done_reg;
      logic [AW-1:0] base;
      logic [AW-1:0] last;

      assign base      = bus.ch_base[gi*AW +: AW];
      assign last      = bus.ch_end[gi*AW +: AW];
      assign grant[gi] = dma_edge & ~pend_reg & win_found & (win_idx == PW'(gi));

      always_ff @(posedge clk) begin
        if (res) begin
          cnt_reg    <= '0;
          active_reg <= 1'b0;
          wrap_reg   <= 1'b0;
          done_reg   <= 1'b0;
        end else begin
          wrap_reg <= 1'b0;
          done_reg <= 1'b0;
          if (bus.ch_start[gi]) begin
            cnt_reg    <= base;
            active_reg <= 1'b1;
          end else if (grant[gi]) begin
            if (cnt_reg == last) begin
              if (bus.ch_loop[gi]) begin
                cnt_reg  <= base;
                wrap_reg <= 1'b1;
              end else begin
                active_reg <= 1'b0;
                done_reg   <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + AW'(1);
            end
          end
          if (bus.ch_stop[gi]) active_reg <= 1'b0;
        end
      end

      assign cnt_arr[gi]    = cnt_reg;
      assign active_vec[gi] = active_reg;
      assign wrap_vec[gi]   = wrap_reg;
      assign done_vec[gi]   = done_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      addr_reg <= '0;
      src_reg  <= 2'b00;
      gnt_reg  <= '0;
      row_reg  <= '0;
      div_reg  <= '0;
      pend_reg <= 1'b0;
      ptr_reg  <= '0;
    end else if (bus.slot_stb) begin
      if (!bus.dma_slot) begin
        addr_reg <= bus.cpu_addr;
        src_reg  <= 2'b00;
        gnt_reg  <= '0;
      end else begin
        div_reg  <= div_wrap ? '0 : div_reg + DW'(1);
        // Any old pending request is served in this slot, so only a fresh divider wrap survives.
        pend_reg <= div_wrap;
        if (pend_reg) begin
          addr_reg <= AW'(row_reg);
          src_reg  <= 2'b01;
          gnt_reg  <= '0;
          row_reg  <= row_reg + REF_W'(1);
        end else if (win_found) begin
          addr_reg <= cnt_arr[win_idx];
          src_reg  <= 2'b10;
          gnt_reg  <= grant;
          ptr_reg  <= (win_idx == PW'(NCH - 1)) ? '0 : win_idx + PW'(1);
        end else begin
          addr_reg <= '0;
          src_reg  <= 2'b11;
          gnt_reg  <= '0;
        end
      end
    end
  end

  assign bus.addr      = addr_reg;
  assign bus.addr_src  = src_reg;
  assign bus.ch_gnt    = gnt_reg;
  assign bus.ch_active = active_vec;
  assign bus.ch_wrap   = wrap_vec;
  assign bus.ch_done   = done_vec;
endmodule

// File: tb/tb_mcu_dma_addr_arb.sv
// Directed bench for mcu_dma_addr_arb: reset, CPU pass-through, refresh cadence,
// round-robin, one-shot and loop channels with start/stop collisions.
module tb_mcu_dma_addr_arb;
  localparam int AW  = 23;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mcu_dma_addr_arb_if #(.AW(AW), .NCH(NCH)) bus ();

  mcu_dma_addr_arb #(.AW(AW), .NCH(NCH), .REF_W(8), .REF_INT(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic do_slot(input logic dma, input logic [NCH-1:0] st);
    @(negedge clk);
    bus.slot_stb = 1'b1;
    bus.dma_slot = dma;
    bus.ch_start = st;
    @(posedge clk);
    #1;
    bus.slot_stb = 1'b0;
    bus.ch_start = '0;
    $display("slot dma=%0d addr=%06h src=%b gnt=%b act=%b wrap=%b done=%b",
             dma, bus.addr, bus.addr_src, bus.ch_gnt, bus.ch_active, bus.ch_wrap, bus.ch_done);
  endtask

  task automatic pulse(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    @(negedge clk);
    bus.ch_start = st;
    bus.ch_stop  = sp;
    @(posedge clk);
    #1;
    bus.ch_start = '0;
    bus.ch_stop  = '0;
  endtask

  task automatic set_ch(input int n, input logic [AW-1:0] b, input logic [AW-1:0] e, input logic lp);
    bus.ch_base[n*AW +: AW] = b;
    bus.ch_end[n*AW +: AW]  = e;
    bus.ch_loop[n]          = lp;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    res          = 1'b1;
    bus.slot_stb = 1'b0;
    bus.dma_slot = 1'b0;
    bus.ch_req   = '0;
    bus.ch_start = '0;
    bus.ch_stop  = '0;
    bus.ch_loop  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    set_ch(0, 23'h40, 23'h50, 1'b0);
    set_ch(1, 23'h80, 23'h90, 1'b0);
    pulse(4'b0001, 4'b0000);
    bus.ch_req = 4'b0001;
    do_slot(1'b1, 4'b0000);
    n_checks++; if (bus.addr !== 23'h40) $display("FAIL pre_reset_addr got %h want %h", bus.addr, 23'h40); else n_pass++;
    @(negedge clk);
    res          = 1'b1;
    bus.slot_stb = 1'b1;
    bus.dma_slot = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.addr !== '0) $display("FAIL reset_addr got %h want 0", bus.addr); else n_pass++;
    n_checks++; if (bus.addr_src !== 2'b00) $display("FAIL reset_src got %b want 00", bus.addr_src); else n_pass++;
    n_checks++; if (bus.ch_gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", bus.ch_gnt); else n_pass++;
    n_checks++; if ({bus.ch_active, bus.ch_wrap, bus.ch_done} !== 12'h000)
      $display("FAIL reset_flags got act=%b wrap=%b done=%b want all 0", bus.ch_active, bus.ch_wrap, bus.ch_done);
    else n_pass++;
    @(negedge clk);
    res          = 1'b0;
    bus.slot_stb = 1'b0;
    pulse(4'b0011, 4'b0000);
    bus.ch_req = 4'b0011;
    do_slot(1'b1, 4'b0000);
    n_checks++; if (bus.ch_gnt !== 4'b0001) $display("FAIL first_gnt got %b want 0001", bus.ch_gnt); else n_pass++;
    n_checks++; if (bus.addr !== 23'h40) $display("FAIL first_addr got %h want %h", bus.addr, 23'h40); else n_pass++;
    n_checks++; if (bus.addr_src !== 2'b10) $display("FAIL first_src got %b want 10", bus.addr_src); else n_pass++;
  endtask

  task automatic test_cpu_pass;
    apply_reset();
    bus.cpu_addr = 23'h12345;
    do_slot(1'b0, 4'b0000);
    n_checks++; if (bus.addr !== 23'h12345) $display("FAIL cpu_addr got %h want 12345", bus.addr); else n_pass++;
    n_checks++; if (bus.addr_src !== 2'b00) $display("FAIL cpu_src got %b want 00", bus.addr_src); else n_pass++;
    n_checks++; if (bus.ch_gnt !== 4'b0000) $display("FAIL cpu_gnt got %b want 0000", bus.ch_gnt); else n_pass++;
    bus.cpu_addr = 23'h00777;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.addr !== 23'h12345) $display("FAIL cpu_hold got %h want 12345", bus.addr); else n_pass++;
  endtask

  task automatic test_refresh;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_src;
    apply_reset();
    for (int k = 1; k <= 9; k++) begin
      do_slot(1'b1, 4'b0000);
      exp_src  = (k == 5 || k == 9) ? 2'b01 : 2'b11;
      exp_addr = (k == 9) ? 23'h1 : 23'h0;
      n_checks++;
      if (bus.addr_src !== exp_src || bus.addr !== exp_addr)
        $display("FAIL refresh_slot%0d got src=%b addr=%h want src=%b addr=%h", k, bus.addr_src, bus.addr, exp_src, exp_addr);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin;
    logic          dma_t [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]    gnt_t [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
    logic [1:0]    src_t [7] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10};
    logic [AW-1:0] adr_t [7] = '{23'h1000, 23'h2000, 23'h3000, 23'h55, 23'h1001, 23'h0, 23'h2001};
    apply_reset();
    set_ch(0, 23'h1000, 23'h10FF, 1'b0);
    set_ch(1, 23'h2000, 23'h20FF, 1'b0);
    set_ch(2, 23'h3000, 23'h30FF, 1'b0);
    bus.cpu_addr = 23'h55;
    pulse(4'b0111, 4'b0000);
    bus.ch_req = 4'b0111;
    for (int k = 0; k < 7; k++) begin
      do_slot(dma_t[k], 4'b0000);
      n_checks++;
      if (bus.ch_gnt !== gnt_t[k] || bus.addr_src !== src_t[k] || bus.addr !== adr_t[k])
        $display("FAIL rr_slot%0d got gnt=%b src=%b addr=%h want gnt=%b src=%b addr=%h",
                 k, bus.ch_gnt, bus.addr_src, bus.addr, gnt_t[k], src_t[k], adr_t[k]);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot;
    apply_reset();
    set_ch(0, 23'h100, 23'h102, 1'b0);
    pulse(4'b0001, 4'b0000);
    bus.ch_req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      do_slot(1'b1, 4'b0000);
      n_checks++;
      if (bus.addr !== 23'h100 + k || bus.ch_gnt !== 4'b0001)
        $display("FAIL oneshot_addr%0d got addr=%h gnt=%b want addr=%h gnt=0001", k, bus.addr, bus.ch_gnt, 23'h100 + k);
      else n_pass++;
      n_checks++;
      if (bus.ch_done !== ((k == 2) ? 4'b0001 : 4'b0000))
        $display("FAIL oneshot_done%0d got %b want %b", k, bus.ch_done, (k == 2) ? 4'b0001 : 4'b0000);
      else n_pass++;
    end
    n_checks++; if (bus.ch_active !== 4'b0000) $display("FAIL oneshot_active got %b want 0000", bus.ch_active); else n_pass++;
    do_slot(1'b1, 4'b0000);
    n_checks++; if (bus.ch_done !== 4'b0000) $display("FAIL oneshot_done_clear got %b want 0000", bus.ch_done); else n_pass++;
    n_checks++; if (bus.addr_src !== 2'b11 || bus.addr !== '0)
      $display("FAIL oneshot_idle got src=%b addr=%h want src=11 addr=0", bus.addr_src, bus.addr);
    else n_pass++;
  endtask

  task automatic test_loop_collisions;
    apply_reset();
    set_ch(0, 23'h100, 23'h102, 1'b1);
    set_ch(1, 23'h200, 23'h2FF, 1'b0);
    pulse(4'b0001, 4'b0000);
    bus.ch_req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      do_slot(1'b1, 4'b0000);
      n_checks++;
      if (bus.addr !== ((k == 3) ? 23'h100 : 23'h100 + k))
        $display("FAIL loop_addr%0d got %h want %h", k, bus.addr, (k == 3) ? 23'h100 : 23'h100 + k);
      else n_pass++;
      n_checks++;
      if (bus.ch_wrap !== ((k == 2) ? 4'b0001 : 4'b0000))
        $display("FAIL loop_wrap%0d got %b want %b", k, bus.ch_wrap, (k == 2) ? 4'b0001 : 4'b0000);
      else n_pass++;
    end
    pulse(4'b0010, 4'b0010);
    n_checks++; if (bus.ch_active !== 4'b0001) $display("FAIL start_stop_active got %b want 0001", bus.ch_active); else n_pass++;
    do_slot(1'b1, 4'b0000);
    n_checks++; if (bus.addr_src !== 2'b01 || bus.addr !== '0)
      $display("FAIL loop_refresh got src=%b addr=%h want src=01 addr=0", bus.addr_src, bus.addr);
    else n_pass++;
    do_slot(1'b1, 4'b0001);
    n_checks++; if (bus.addr_src !== 2'b11 || bus.ch_gnt !== 4'b0000)
      $display("FAIL start_on_grant got src=%b gnt=%b want src=11 gnt=0000", bus.addr_src, bus.ch_gnt);
    else n_pass++;
    do_slot(1'b1, 4'b0000);
    n_checks++; if (bus.addr !== 23'h100 || bus.ch_gnt !== 4'b0001)
      $display("FAIL restart_addr got addr=%h gnt=%b want addr=100 gnt=0001", bus.addr, bus.ch_gnt);
    else n_pass++;
  endtask

  initial begin
    bus.slot_stb = 1'b0;
    bus.dma_slot = 1'b0;
    bus.cpu_addr = '0;
    bus.ch_req   = '0;
    bus.ch_start = '0;
    bus.ch_stop  = '0;
    bus.ch_loop  = '0;
    bus.ch_base  = '0;
    bus.ch_end   = '0;
    test_reset();
    test_cpu_pass();
    test_refresh();
    test_round_robin();
    test_oneshot();
    test_loop_collisions();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
